// File: rtl/forwarding_scoreboard.sv
// Forwarding/hazard unit: shadows EX..WB destinations, registers EX operand forward selects.
// Load-use stall is combinational from state + ID; a multi-cycle op holds EX for MC_LAT cycles.
module forwarding_scoreboard #(
  parameter int ADDR_W     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 2,
  parameter int MC_LAT     = 4,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [ADDR_W-1:0]           id_dst,
  input  logic                        id_reg_write,
  input  logic                        id_is_load,
  input  logic                        id_is_mc,
  input  logic                        flush,
  output logic                        stall_id,
  output logic                        ex_hold,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_ex
);

  localparam int CNT_W = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  // The entry in stage FWD_STAGES is never consulted: by the time an ID op reaches EX it has retired.
  logic [FWD_STAGES-1:0] vld_q, vld_d;
  logic [FWD_STAGES-1:0] wr_q, wr_d;
  logic [ADDR_W-1:0]     dst_q [FWD_STAGES];
  logic [ADDR_W-1:0]     dst_d [FWD_STAGES];
  logic                  ld0_q, ld0_d;
  logic [CNT_W-1:0]      mc_cnt_q, mc_cnt_d;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel_q, fwd_sel_d;

  logic [SEL_W-1:0]   sel_new [NUM_SRC];
  logic [NUM_SRC-1:0] hit0;
  logic               load_use;
  logic               issue;

  // Descending scan so the nearest matching stage overwrites farther ones.
  always_comb begin
    hit0 = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_new[i] = '0;
      for (int s = FWD_STAGES - 1; s >= 0; s--) begin
        if (id_src_used[i] && vld_q[s] && wr_q[s] && (dst_q[s] != '0) &&
            (dst_q[s] == id_src_addr[i*ADDR_W +: ADDR_W]))
          sel_new[i] = SEL_W'(s + 1);
      end
      hit0[i] = (sel_new[i] == SEL_W'(1));
    end
  end

  assign load_use   = ld0_q & (|hit0);
  assign ex_hold    = (mc_cnt_q != '0);
  assign stall_id   = id_valid & ~flush & (load_use | ex_hold);
  assign issue      = id_valid & ~stall_id & ~flush;
  assign fwd_sel_ex = fwd_sel_q;

  always_comb begin
    vld_d    = vld_q;
    wr_d     = wr_q;
    dst_d    = dst_q;
    ld0_d    = ld0_q;
    mc_cnt_d = mc_cnt_q;
    fwd_sel_d = fwd_sel_q;

    if (issue) begin
      vld_d[0] = 1'b1;
      wr_d[0]  = id_reg_write;
      dst_d[0] = id_dst;
      ld0_d    = id_is_load;
    end else if (!(ex_hold && !flush)) begin
      vld_d[0] = 1'b0;
      wr_d[0]  = 1'b0;
      dst_d[0] = '0;
      ld0_d    = 1'b0;
    end

    // A held multi-cycle op has not left EX yet, so MEM sees a bubble.
    if (ex_hold) begin
      vld_d[1] = 1'b0;
      wr_d[1]  = 1'b0;
      dst_d[1] = '0;
    end else begin
      vld_d[1] = vld_q[0];
      wr_d[1]  = wr_q[0];
      dst_d[1] = dst_q[0];
    end
    for (int s = 2; s < FWD_STAGES; s++) begin
      vld_d[s] = vld_q[s-1];
      wr_d[s]  = wr_q[s-1];
      dst_d[s] = dst_q[s-1];
    end

    if (flush)
      mc_cnt_d = '0;
    else if (ex_hold)
      mc_cnt_d = mc_cnt_q - CNT_W'(1);
    else if (issue && id_is_mc)
      mc_cnt_d = CNT_W'(MC_LAT - 1);

    if (flush)
      fwd_sel_d = '0;
    else if (issue) begin
      for (int i = 0; i < NUM_SRC; i++)
        fwd_sel_d[i*SEL_W +: SEL_W] = sel_new[i];
    end else if (!ex_hold)
      fwd_sel_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q     <= '0;
      wr_q      <= '0;
      ld0_q     <= 1'b0;
      mc_cnt_q  <= '0;
      fwd_sel_q <= '0;
      for (int s = 0; s < FWD_STAGES; s++)
        dst_q[s] <= '0;
    end else begin
      vld_q     <= vld_d;
      wr_q      <= wr_d;
      dst_q     <= dst_d;
      ld0_q     <= ld0_d;
      mc_cnt_q  <= mc_cnt_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Bench for forwarding_scoreboard: directed table, flush/reset sequences, random vs. instruction-level model.
module tb_forwarding_scoreboard;

  localparam int AW  = 5;
  localparam int FWD = 2;
  localparam int MC  = 4;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [9:0] id_src_addr;
  logic [1:0] id_src_used;
  logic [4:0] id_dst;
  logic       id_reg_write;
  logic       id_is_load;
  logic       id_is_mc;
  logic       flush;
  logic       stall_id;
  logic       ex_hold;
  logic [3:0] fwd_sel_ex;

  forwarding_scoreboard #(.ADDR_W(AW), .NUM_SRC(2), .FWD_STAGES(FWD), .MC_LAT(MC)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src_addr(id_src_addr),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .flush(flush),
    .stall_id(stall_id), .ex_hold(ex_hold), .fwd_sel_ex(fwd_sel_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int s0, input int s1, input logic [1:0] used,
                       input int dst, input logic wr, input logic ld, input logic mc, input logic fl);
    id_valid     = v;
    id_src_addr  = {5'(s1), 5'(s0)};
    id_src_used  = used;
    id_dst       = 5'(dst);
    id_reg_write = wr;
    id_is_load   = ld;
    id_is_mc     = mc;
    flush        = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v; int s0; int s1; logic [1:0] used; int dst; logic wr; logic ld; logic mc;
    logic e_stall; logic e_hold; int e_sel0; int e_sel1;
  } vec_t;

  function automatic vec_t mk(input logic v, input int s0, input int s1, input logic [1:0] used,
                              input int dst, input logic wr, input logic ld, input logic mc,
                              input logic es, input logic eh, input int e0, input int e1);
    vec_t r;
    r.v = v; r.s0 = s0; r.s1 = s1; r.used = used; r.dst = dst; r.wr = wr; r.ld = ld; r.mc = mc;
    r.e_stall = es; r.e_hold = eh; r.e_sel0 = e0; r.e_sel1 = e1;
    return r;
  endfunction

  // Instruction-level reference: what sits in EX, what has left EX, and how long EX stays busy.
  typedef struct { bit v; int dst; bit wr; bit ld; } ins_t;
  ins_t m_ex;
  ins_t m_post [FWD];
  int   m_busy;
  int   m_sel [2];

  function automatic bit produces(input ins_t x, input int r);
    return x.v && x.wr && (x.dst != 0) && (x.dst == r);
  endfunction

  task automatic model_reset();
    ins_t b;
    b = '{v: 0, dst: 0, wr: 0, ld: 0};
    m_ex = b;
    for (int k = 0; k < FWD; k++) m_post[k] = b;
    m_busy = 0;
    m_sel[0] = 0;
    m_sel[1] = 0;
  endtask

  vec_t tbl [28];

  initial begin
    int   r [2];
    bit   m_hold, m_lu, m_stall, iss;
    int   ns [2];
    ins_t cand [FWD];
    ins_t bub, leaving, nw;
    logic v, wr, ld, mc, fl;
    logic [1:0] used;
    int   dst;

    bub = '{v: 0, dst: 0, wr: 0, ld: 0};

    // Reset state
    rst_n = 1'b0;
    drive(1, 3, 4, 2'b11, 5, 1, 0, 0, 0);
    step(); step();
    @(negedge clk);
    chk("reset_stall", 32'(stall_id), 0);
    chk("reset_hold",  32'(ex_hold), 0);
    chk("reset_sel",   32'(fwd_sel_ex), 0);
    rst_n = 1'b1;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step();

    //            v  s0 s1 used  dst wr ld mc   stall hold sel0 sel1
    tbl[0]  = mk(1, 1, 2, 2'b11, 3, 1, 0, 0,   0, 0, 0, 0);
    tbl[1]  = mk(1, 3, 1, 2'b11, 7, 1, 0, 0,   0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 1, 0);
    tbl[3]  = mk(1, 1, 2, 2'b11, 3, 1, 0, 0,   0, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[5]  = mk(1, 3, 1, 2'b11, 7, 1, 0, 0,   0, 0, 0, 0);
    tbl[6]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 2, 0);
    tbl[7]  = mk(1, 1, 2, 2'b11, 5, 1, 0, 0,   0, 0, 0, 0);
    tbl[8]  = mk(1, 1, 2, 2'b11, 5, 1, 0, 0,   0, 0, 0, 0);
    tbl[9]  = mk(1, 5, 5, 2'b11, 2, 1, 0, 0,   0, 0, 0, 0);
    tbl[10] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 1, 1);
    tbl[11] = mk(1, 1, 0, 2'b01, 4, 1, 1, 0,   0, 0, 0, 0);
    tbl[12] = mk(1, 4, 4, 2'b11, 6, 1, 0, 0,   1, 0, 0, 0);
    tbl[13] = mk(1, 4, 4, 2'b11, 6, 1, 0, 0,   0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 2, 2);
    tbl[15] = mk(1, 1, 2, 2'b11, 0, 1, 0, 0,   0, 0, 0, 0);
    tbl[16] = mk(1, 0, 0, 2'b11, 10, 1, 0, 0,  0, 0, 0, 0);
    tbl[17] = mk(1, 1, 2, 2'b11, 9, 0, 0, 0,   0, 0, 0, 0);
    tbl[18] = mk(1, 9, 9, 2'b11, 13, 1, 0, 0,  0, 0, 0, 0);
    tbl[19] = mk(1, 1, 0, 2'b01, 11, 1, 1, 0,  0, 0, 0, 0);
    tbl[20] = mk(1, 11, 11, 2'b00, 12, 1, 0, 0, 0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 0, 0);
    tbl[22] = mk(1, 1, 2, 2'b11, 8, 1, 0, 1,   0, 0, 0, 0);
    tbl[23] = mk(1, 8, 2, 2'b11, 1, 1, 0, 0,   1, 1, 0, 0);
    tbl[24] = mk(1, 8, 2, 2'b11, 1, 1, 0, 0,   1, 1, 0, 0);
    tbl[25] = mk(1, 8, 2, 2'b11, 1, 1, 0, 0,   1, 1, 0, 0);
    tbl[26] = mk(1, 8, 2, 2'b11, 1, 1, 0, 0,   0, 0, 0, 0);
    tbl[27] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0,   0, 0, 1, 0);

    for (int n = 0; n < 28; n++) begin
      drive(tbl[n].v, tbl[n].s0, tbl[n].s1, tbl[n].used, tbl[n].dst, tbl[n].wr, tbl[n].ld, tbl[n].mc, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_stall", n), 32'(stall_id), 32'(tbl[n].e_stall));
      chk($sformatf("tbl%0d_hold", n),  32'(ex_hold), 32'(tbl[n].e_hold));
      chk($sformatf("tbl%0d_sel0", n),  32'(fwd_sel_ex[1:0]), 32'(tbl[n].e_sel0));
      chk($sformatf("tbl%0d_sel1", n),  32'(fwd_sel_ex[3:2]), 32'(tbl[n].e_sel1));
      step();
    end

    // Flush during the second busy cycle of a multi-cycle op
    drive(1, 1, 2, 2'b11, 8, 1, 0, 1, 0);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fl_busy1_hold", 32'(ex_hold), 1);
    step();
    drive(1, 8, 2, 2'b11, 1, 1, 0, 0, 1);
    @(negedge clk);
    chk("fl_busy2_hold",  32'(ex_hold), 1);
    chk("fl_busy2_stall", 32'(stall_id), 0);
    step();
    drive(1, 8, 2, 2'b11, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("fl_after_hold",  32'(ex_hold), 0);
    chk("fl_after_stall", 32'(stall_id), 0);
    chk("fl_after_sel",   32'(fwd_sel_ex), 0);
    step();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step(); step();

    // Reset asserted while a stall and a forward select are live
    drive(1, 1, 2, 2'b11, 3, 1, 0, 0, 0);
    step();
    drive(1, 3, 2, 2'b11, 8, 1, 0, 1, 0);
    step();
    drive(1, 8, 2, 2'b11, 1, 1, 0, 0, 0);
    @(negedge clk);
    chk("rs_pre_stall", 32'(stall_id), 1);
    chk("rs_pre_hold",  32'(ex_hold), 1);
    chk("rs_pre_sel",   32'(fwd_sel_ex), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rs_post_stall", 32'(stall_id), 0);
    chk("rs_post_hold",  32'(ex_hold), 0);
    chk("rs_post_sel",   32'(fwd_sel_ex), 0);
    step();

    // Random traffic against the instruction-level model
    rst_n = 1'b0;
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      v    = ($urandom_range(0, 9) < 8);
      r[0] = $urandom_range(0, 5);
      r[1] = $urandom_range(0, 5);
      used = 2'($urandom_range(0, 3));
      dst  = $urandom_range(0, 5);
      wr   = ($urandom_range(0, 3) != 0);
      ld   = ($urandom_range(0, 3) == 0);
      mc   = ($urandom_range(0, 9) == 0);
      fl   = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      drive(v, r[0], r[1], used, dst, wr, ld, mc, fl);

      m_hold = (m_busy > 0);
      m_lu = 0;
      for (int i = 0; i < 2; i++)
        if (used[i] && m_ex.ld && produces(m_ex, r[i])) m_lu = 1;
      m_stall = v && !fl && (m_lu || m_hold);

      @(negedge clk);
      chk("rnd_stall", 32'(stall_id), 32'(m_stall));
      chk("rnd_hold",  32'(ex_hold), 32'(m_hold));
      chk("rnd_sel0",  32'(fwd_sel_ex[1:0]), 32'(m_sel[0]));
      chk("rnd_sel1",  32'(fwd_sel_ex[3:2]), 32'(m_sel[1]));

      if (!rst_n) begin
        model_reset();
      end else begin
        iss = v && !m_stall && !fl;
        cand[0] = m_ex;
        for (int k = 1; k < FWD; k++) cand[k] = m_post[k-1];
        for (int i = 0; i < 2; i++) begin
          ns[i] = 0;
          for (int k = FWD - 1; k >= 0; k--)
            if (used[i] && produces(cand[k], r[i])) ns[i] = k + 1;
        end
        for (int i = 0; i < 2; i++) begin
          if (fl)          m_sel[i] = 0;
          else if (iss)    m_sel[i] = ns[i];
          else if (!m_hold) m_sel[i] = 0;
        end
        leaving = m_hold ? bub : m_ex;
        for (int k = FWD - 1; k >= 1; k--) m_post[k] = m_post[k-1];
        m_post[0] = leaving;
        nw = '{v: 1, dst: dst, wr: wr, ld: ld};
        if (iss)                 m_ex = nw;
        else if (!(m_hold && !fl)) m_ex = bub;
        if (fl)               m_busy = 0;
        else if (m_hold)      m_busy = m_busy - 1;
        else if (iss && mc)   m_busy = MC - 1;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
